// File: rtl/button_conditioner_if.sv
// Signal bundle between raw board inputs and the button/switch conditioner.
// The master side drives the raw pins; the slave side is the conditioner.
interface button_conditioner_if;
  logic [3:0]  btn_in;
  logic [15:0] sw_in;
  logic [3:0]  btn_out;
  logic [3:0]  btn_press_out;
  logic [3:0]  btn_release_out;
  logic [15:0] sw_out;
  logic        sw_changed_out;

  modport master (
    output btn_in,
    output sw_in,
    input  btn_out,
    input  btn_press_out,
    input  btn_release_out,
    input  sw_out,
    input  sw_changed_out
  );

  modport slave (
    input  btn_in,
    input  sw_in,
    output btn_out,
    output btn_press_out,
    output btn_release_out,
    output sw_out,
    output sw_changed_out
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces 4 pushbuttons and 16 slide switches, and produces
// registered edge pulses for button press/release and any switch change.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  button_conditioner_if.slave  bus_io
);
  localparam int unsigned NumCh = 20;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // Channel layout: [3:0] buttons, [19:4] switches.
  logic [NumCh-1:0]                   raw;
  logic [SYNC_STAGES-1:0][NumCh-1:0]  sync_q, sync_d;
  logic [NumCh-1:0]                   deb_q, deb_d;
  logic [NumCh-1:0][CntW-1:0]         cnt_q, cnt_d;
  logic [3:0]                         press_q, press_d;
  logic [3:0]                         release_q, release_d;
  logic                               sw_chg_q, sw_chg_d;

  assign raw = {bus_io.sw_in, bus_io.btn_in};

  // Stage 0 takes the raw pins; the last stage feeds the debouncers.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NumCh; i++) begin
      if (sync_q[SYNC_STAGES-1][i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        deb_d[i] = sync_q[SYNC_STAGES-1][i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end
    end
  end

  // Pulses are registered alongside the debounced state so they line up
  // with the first cycle in which the new level is visible.
  always_comb begin
    press_d   = deb_d[3:0] & ~deb_q[3:0];
    release_d = ~deb_d[3:0] & deb_q[3:0];
    sw_chg_d  = |(deb_d[19:4] ^ deb_q[19:4]);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q    <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      sw_chg_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      sw_chg_q  <= sw_chg_d;
    end
  end

  assign bus_io.btn_out         = deb_q[3:0];
  assign bus_io.sw_out          = deb_q[19:4];
  assign bus_io.btn_press_out   = press_q;
  assign bus_io.btn_release_out = release_q;
  assign bus_io.sw_changed_out  = sw_chg_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: table vectors, hand-timed corner cases and
// randomized traffic against a sliding-window reference model.
module tb_button_conditioner;
  localparam int unsigned Deb  = 8;
  localparam int unsigned Sync = 2;
  localparam int unsigned Hist = Deb + Sync;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(Deb),
    .SYNC_STAGES    (Sync)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus_io(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: h[j] is the raw sample taken j edges ago. A channel flips when the
  // Deb samples that have reached the end of the synchronizer all disagree
  // with its debounced level.
  logic [19:0] h [Hist];
  logic [19:0] md;
  logic [3:0]  m_press, m_rel;
  logic        m_chg;
  int          press_seen, rel_seen, chg_seen;

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] sw;
    int          cycles;
    logic [3:0]  exp_btn;
    logic [15:0] exp_sw;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < Hist; j++) h[j] = '0;
    md      = '0;
    m_press = '0;
    m_rel   = '0;
    m_chg   = 1'b0;
  endtask

  task automatic model_edge();
    logic [19:0] all_diff;
    logic [19:0] nd;
    for (int j = Hist - 1; j > 0; j--) h[j] = h[j-1];
    h[0] = {bus.sw_in, bus.btn_in};
    all_diff = '1;
    for (int j = Sync; j < Hist; j++) all_diff &= h[j] ^ md;
    nd      = md ^ all_diff;
    m_press = nd[3:0] & ~md[3:0];
    m_rel   = ~nd[3:0] & md[3:0];
    m_chg   = |(nd[19:4] ^ md[19:4]);
    md      = nd;
  endtask

  task automatic clear_seen();
    press_seen = 0;
    rel_seen   = 0;
    chg_seen   = 0;
  endtask

  // One clock: model steps on the rising edge, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge clk_in);
    if (rst_in) model_reset();
    else model_edge();
    @(negedge clk_in);
    check("model",
          {bus.btn_out, bus.sw_out, bus.btn_press_out, bus.btn_release_out, bus.sw_changed_out},
          {md[3:0], md[19:4], m_press, m_rel, m_chg});
    press_seen += $countones(bus.btn_press_out);
    rel_seen   += $countones(bus.btn_release_out);
    chg_seen   += int'(bus.sw_changed_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  int ridx, sidx;
  logic hi_seen;

  initial begin
    tbl[0] = '{4'b0001, 16'h0000, 20, 4'b0001, 16'h0000};
    tbl[1] = '{4'b0000, 16'h0000, 20, 4'b0000, 16'h0000};
    tbl[2] = '{4'b0100, 16'h0000,  5, 4'b0000, 16'h0000};
    tbl[3] = '{4'b0000, 16'h0000, 20, 4'b0000, 16'h0000};
    tbl[4] = '{4'b0000, 16'hA005, 20, 4'b0000, 16'hA005};
    tbl[5] = '{4'b0110, 16'h5A5A, 20, 4'b0110, 16'h5A5A};
    tbl[6] = '{4'b1000, 16'hFFFF, 20, 4'b1000, 16'hFFFF};
    tbl[7] = '{4'b0000, 16'h0000, 20, 4'b0000, 16'h0000};

    bus.btn_in = '0;
    bus.sw_in  = '0;
    model_reset();
    clear_seen();
    #1;
    check("reset_state",
          {bus.btn_out, bus.sw_out, bus.btn_press_out, bus.btn_release_out, bus.sw_changed_out},
          '0);
    run(2);
    rst_in = 1'b0;

    foreach (tbl[v]) begin
      bus.btn_in = tbl[v].btn;
      bus.sw_in  = tbl[v].sw;
      run(tbl[v].cycles);
      check($sformatf("vec%0d_btn", v), bus.btn_out, tbl[v].exp_btn);
      check($sformatf("vec%0d_sw", v), bus.sw_out, tbl[v].exp_sw);
    end

    // Clean press: first sampled at call 1, visible after call 1+Sync+Deb-1.
    clear_seen();
    ridx = -1;
    bus.btn_in = 4'b0001;
    for (int i = 1; i <= 11; i++) begin
      cycle();
      if (ridx < 0 && bus.btn_out[0]) ridx = i;
      if (i == 10) check("press_pulse", bus.btn_press_out, 4'b0001);
      if (i == 11) check("press_pulse_end", bus.btn_press_out, 4'b0000);
    end
    check("press_latency", ridx, 10);
    check("press_others", bus.btn_out, 4'b0001);
    check("press_count", press_seen, 1);
    bus.btn_in = 4'b0000;
    run(12);

    // Short glitch on btn[2] must be swallowed.
    clear_seen();
    hi_seen = 1'b0;
    bus.btn_in = 4'b0100;
    for (int i = 0; i < 5; i++) begin cycle(); hi_seen |= bus.btn_out[2]; end
    bus.btn_in = 4'b0000;
    for (int i = 0; i < 15; i++) begin cycle(); hi_seen |= bus.btn_out[2]; end
    check("glitch_level", hi_seen, 1'b0);
    check("glitch_pulses", press_seen + rel_seen, 0);

    // Bounce: one low clock restarts the count.
    bus.btn_in = 4'b0100;
    run(4);
    bus.btn_in = 4'b0000;
    run(1);
    bus.btn_in = 4'b0100;
    ridx = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (ridx < 0 && bus.btn_out[2]) ridx = i;
    end
    check("bounce_latency", ridx, 10);
    bus.btn_in = 4'b0000;
    run(12);

    // Release on btn[3].
    bus.btn_in = 4'b1000;
    run(12);
    check("release_pre", bus.btn_out, 4'b1000);
    clear_seen();
    ridx = -1;
    bus.btn_in = 4'b0000;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (ridx < 0 && !bus.btn_out[3]) ridx = i;
    end
    check("release_latency", ridx, 10);
    check("release_count", rel_seen, 1);
    check("release_no_press", press_seen, 0);

    // Multi-bit switch change gives one pulse.
    clear_seen();
    sidx = -1;
    bus.sw_in = 16'hA005;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (sidx < 0 && bus.sw_out == 16'hA005) sidx = i;
    end
    check("sw_latency", sidx, 10);
    check("sw_chg_count", chg_seen, 1);
    bus.sw_in = 16'h0001;
    run(12);
    check("sw_settle", bus.sw_out, 16'h0001);

    // Reset in the middle of btn[1]'s count; sw[0] held high throughout.
    bus.btn_in = 4'b0010;
    run(5);
    #2 rst_in = 1'b1;
    #1;
    check("async_reset",
          {bus.btn_out, bus.sw_out, bus.btn_press_out, bus.btn_release_out, bus.sw_changed_out},
          '0);
    run(3);
    rst_in = 1'b0;
    clear_seen();
    ridx = -1;
    sidx = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (ridx < 0 && bus.btn_out[1]) ridx = i;
      if (sidx < 0 && bus.sw_out[0]) sidx = i;
    end
    check("rst_btn_latency", ridx, 10);
    check("rst_sw_latency", sidx, 10);
    check("rst_sw_chg", chg_seen, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (rst_in) rst_in = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst_in = 1'b1;
      if ($urandom_range(0, 4) == 0) begin
        int unsigned b;
        b = $urandom_range(0, 19);
        if (b < 4) bus.btn_in[b] = ~bus.btn_in[b];
        else bus.sw_in[b-4] = ~bus.sw_in[b-4];
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250_000 (5 ms at 50 MHz), meaning the number of consecutive clocks a synchronized input must differ from its debounced state before that state changes; legal range 2..2^20.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the flip-flop depth of each input synchronizer; legal range 2..4.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port btn_in, input, 4 bits: raw asynchronous pushbuttons, bit order {btnd, btnu, btnr, btnl}, high = pressed.
REQ-006 SHALL have port sw_in, input, 16 bits: raw asynchronous slide switches.
REQ-007 SHALL have port btn_out, output, 4 bits: debounced button levels, same bit order; drives btnl/btnr/btnu/btnd of user_control.
REQ-008 SHALL have port btn_press_out, output, 4 bits: one-cycle pulse per bit on each debounced 0->1 transition.
REQ-009 SHALL have port btn_release_out, output, 4 bits: one-cycle pulse per bit on each debounced 1->0 transition.
REQ-010 SHALL have port sw_out, output, 16 bits: debounced switch levels; drives sw of user_control.
REQ-011 SHALL have port sw_changed_out, output, 1 bit: one-cycle pulse when any sw_out bit changes.

Function
REQ-012 SHALL pass each of the 20 raw inputs through its own SYNC_STAGES-deep synchronizer chain; no combinational path from any raw input to any output.
REQ-013 SHALL keep, per input, a debounced state register D and a counter C of width $clog2(DEBOUNCE_CYCLES).
REQ-014 Per input, each clock, with S the synchronizer output: if S == D then C <= 0; else if C == DEBOUNCE_CYCLES-1 then D <= S and C <= 0; else C <= C+1.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized clocks SHALL leave D unchanged; any single cycle with S == D SHALL restart the count from 0.
REQ-016 Latency: a clean raw transition first sampled at edge k SHALL appear on btn_out/sw_out at edge k + SYNC_STAGES + DEBOUNCE_CYCLES - 1 (edge k+9 for defaults SYNC_STAGES=2, DEBOUNCE_CYCLES=8).
REQ-017 btn_press_out[i] / btn_release_out[i] SHALL be registered, asserted for exactly the one cycle following the edge at which btn_out[i] rises / falls, and never both high together.
REQ-018 sw_changed_out SHALL be high for exactly the cycle following any edge at which one or more sw_out bits change; simultaneous changes on several bits SHALL produce one pulse.
REQ-019 Counters SHALL never wrap; C saturates at the update point defined in REQ-014.
REQ-020 All 20 channels SHALL be independent; simultaneous activity on several inputs SHALL not alter any channel's timing.

Reset
REQ-021 On rst_in high, asynchronously: all synchronizer stages, D, and C SHALL go to 0; btn_out = 0, sw_out = 0, and all pulse outputs = 0.
REQ-022 After rst_in deasserts, a switch held high SHALL appear on sw_out after the REQ-016 latency, measured from the first post-reset edge, and SHALL produce one sw_changed_out pulse.
REQ-023 Reset asserted mid-count SHALL discard the partial count; counting SHALL restart from 0 after release.

Verification (DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
REQ-024 Clean press: btn_in[0] 0->1 held, first sampled at edge 10 -> btn_out[0]=1 after edge 19; btn_press_out[0]=1 for that one cycle only; other bits stay 0.
REQ-025 Glitch reject: btn_in[2] high for 5 clocks then low -> btn_out[2] stays 0, no pulses; a bounce of 1 low clock inside a 12-clock press restarts the count, so output rises 8 synchronized clocks after the bounce ends.
REQ-026 Release: btn_in[3] held high, then low for 20 clocks -> btn_out[3] falls at REQ-016 latency; btn_release_out[3] pulses once; btn_press_out[3] stays 0.
REQ-027 Switches: sw_in 0x0000->0xA005 in one clock -> sw_out=0xA005 at REQ-016 latency; exactly one sw_changed_out pulse.
REQ-028 Reset mid-count: press btn_in[1], assert rst_in asynchronously after 5 clocks for 3 clocks while held -> outputs 0 immediately; btn_out[1] rises at REQ-016 latency counted from the first post-reset edge.
